// File: rtl/component_sequencer_fsm_if.sv
// Slice-control to component-sequencer handshake and stage-window bus.
// master = slice control side, slave = the sequencer.
interface component_sequencer_fsm_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [CNT_W-1:0] block_num;
    logic             stall;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] sequence_counter;
    logic             dc_vlc_reset;
    logic             dc_vlc_output_enable;
    logic [CNT_W-1:0] dc_vlc_counter;
    logic             ac_vlc_reset;
    logic             ac_vlc_output_enable;
    logic             ac_vlc_output_flush;
    logic [CNT_W-1:0] ac_vlc_counter;

    modport master (
        output start, block_num, stall, abort,
        input  busy, done, err, sequence_counter,
        input  dc_vlc_reset, dc_vlc_output_enable, dc_vlc_counter,
        input  ac_vlc_reset, ac_vlc_output_enable, ac_vlc_output_flush, ac_vlc_counter
    );

    modport slave (
        input  start, block_num, stall, abort,
        output busy, done, err, sequence_counter,
        output dc_vlc_reset, dc_vlc_output_enable, dc_vlc_counter,
        output ac_vlc_reset, ac_vlc_output_enable, ac_vlc_output_flush, ac_vlc_counter
    );
endinterface

// File: rtl/component_sequencer_fsm.sv
// Start-triggered DC/AC VLC window sequencer; all outputs registered, valid alongside sequence_counter.
// stall freezes counter, state and outputs; abort cancels the job to IDLE on the next cycle.
module component_sequencer_fsm #(
    parameter int CNT_W      = 32,
    parameter int DCT_LAT    = 10,
    parameter int DC_VLC_LAT = 44,
    parameter int DC_SETUP   = 7,
    parameter int AC_SETUP   = 6,
    parameter int COEFS      = 63,
    parameter int MAX_BLOCKS = 256
) (
    input  logic                    clock,
    input  logic                    reset_n,
    component_sequencer_fsm_if.slave bus
);
    localparam int TW = CNT_W + 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [TW-1:0] K_ONE   = TW'(1);
    localparam logic [TW-1:0] K_TAIL  = TW'(8);
    localparam logic [TW-1:0] K_DCT   = TW'(DCT_LAT);
    localparam logic [TW-1:0] K_DCVLC = TW'(DC_VLC_LAT);
    localparam logic [TW-1:0] K_DCS   = TW'(DC_SETUP);
    localparam logic [TW-1:0] K_ACS   = TW'(AC_SETUP);
    localparam logic [TW-1:0] K_COEFS = TW'(COEFS);
    localparam logic [TW-1:0] K_MAXB  = TW'(MAX_BLOCKS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    n_q, n_d, t0_q, t0_d, t1_q, t1_d, e_q, e_d;

    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             dc_rst_q, dc_rst_d, dc_oe_q, dc_oe_d;
    logic             ac_rst_q, ac_rst_d, ac_oe_q, ac_oe_d, flush_q, flush_d;
    logic [CNT_W-1:0] dc_cnt_q, dc_cnt_d, ac_cnt_q, ac_cnt_d;

    logic [TW-1:0]    n_in, cnt_x;
    logic [TW-1:0]    dc_rst_end, dc_oe_lo, dc_oe_end, ac_oe_lo, ac_oe_end;
    logic             act;

    // Thresholds are widened by 8 bits so large N cannot wrap the window bounds.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        e_d     = e_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        n_in    = TW'(bus.block_num);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (n_in != '0 && n_in <= K_MAXB) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        n_d     = n_in;
                        t0_d    = K_DCT + n_in;
                        t1_d    = K_DCT + n_in + K_DCVLC;
                        e_d     = K_DCT + n_in + K_DCVLC + K_COEFS * n_in + K_TAIL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!bus.stall) begin
                    if (TW'(cnt_q) == e_q - K_ONE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.abort || !bus.stall) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode from the next count so the registered outputs line up with sequence_counter.
    always_comb begin
        cnt_x      = TW'(cnt_d);
        act        = (state_d != S_IDLE);
        dc_rst_end = t0_d + n_d + K_TAIL;
        dc_oe_lo   = t0_d + K_DCS;
        dc_oe_end  = t0_d + K_DCS + n_d;
        ac_oe_lo   = t1_d + K_ACS;
        ac_oe_end  = t1_d + K_ACS + K_COEFS * n_d;

        busy_d   = act;
        dc_rst_d = act && (cnt_x > t0_d) && (cnt_x < dc_rst_end);
        dc_oe_d  = act && (cnt_x >= dc_oe_lo) && (cnt_x < dc_oe_end);
        ac_rst_d = act && (cnt_x > t1_d) && (cnt_x < e_d);
        ac_oe_d  = act && (cnt_x >= ac_oe_lo) && (cnt_x < ac_oe_end);
        flush_d  = act && (cnt_x == ac_oe_end);
        dc_cnt_d = dc_rst_d ? CNT_W'(cnt_x - t0_d - K_ONE) : '0;
        ac_cnt_d = ac_rst_d ? CNT_W'(cnt_x - t1_d - K_ONE) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            e_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dc_rst_q <= 1'b0;
            dc_oe_q  <= 1'b0;
            ac_rst_q <= 1'b0;
            ac_oe_q  <= 1'b0;
            flush_q  <= 1'b0;
            dc_cnt_q <= '0;
            ac_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            t0_q     <= t0_d;
            t1_q     <= t1_d;
            e_q      <= e_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dc_rst_q <= dc_rst_d;
            dc_oe_q  <= dc_oe_d;
            ac_rst_q <= ac_rst_d;
            ac_oe_q  <= ac_oe_d;
            flush_q  <= flush_d;
            dc_cnt_q <= dc_cnt_d;
            ac_cnt_q <= ac_cnt_d;
        end
    end

    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.err                  = err_q;
    assign bus.sequence_counter     = cnt_q;
    assign bus.dc_vlc_reset         = dc_rst_q;
    assign bus.dc_vlc_output_enable = dc_oe_q;
    assign bus.dc_vlc_counter       = dc_cnt_q;
    assign bus.ac_vlc_reset         = ac_rst_q;
    assign bus.ac_vlc_output_enable = ac_oe_q;
    assign bus.ac_vlc_output_flush  = flush_q;
    assign bus.ac_vlc_counter       = ac_cnt_q;
endmodule
